add8_seq: RTL and testbench

- Multi-byte add sequencer that time-shares one external 8-bit adder (add8).
- Accepts two WORDS-byte operands and a carry-in over a valid/ready request handshake.
- Feeds the shared adder one byte per cycle, LSB first, chaining the carry through a register.
- Returns the full-width sum and final carry over a valid/ready response handshake.
- Sits between a requester (test sequencer or datapath control) and the add8 instance.

---
 rtl/add8_seq.sv | 139 +++++++++++++
 tb/tb_add8_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add8_seq.sv
// Multi-byte add sequencer: streams two WORDS-byte operands LSB-first through one
// shared external 8-bit adder, chaining the carry through a register.
module add8_seq #(
    parameter int unsigned WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [8*WORDS-1:0]   op_a,
    input  logic [8*WORDS-1:0]   op_b,
    input  logic                 op_cin,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [8*WORDS-1:0]   rsp_sum,
    output logic                 rsp_cout,
    output logic [7:0]           add_a,
    output logic [7:0]           add_b,
    output logic                 add_cin,
    input  logic [7:0]           add_sum,
    input  logic                 add_cout,
    output logic                 busy
);

    localparam int unsigned W        = 8 * WORDS;
    localparam int unsigned IDX_W    = $clog2((WORDS < 2) ? 2 : WORDS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [7:0]       add_a_q, add_a_d;
    logic [7:0]       add_b_q, add_b_d;
    logic             add_cin_q, add_cin_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             busy_q, busy_d;

    // Next state, datapath updates, and registered outputs decoded from the next state.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        add_a_d     = 8'd0;
        add_b_d     = 8'd0;
        add_cin_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    carry_d = op_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // add_sum is only sampled here, so X from the adder elsewhere never lands in a flop
                sum_d[8*idx_q +: 8] = add_sum;
                carry_d             = add_cout;
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d = IDX_W'(idx_q + 1'b1);
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Adder drive is registered from next-state values so it lines up with idx_q/carry_q in RUN
        if (state_d == RUN) begin
            add_a_d   = a_d[8*idx_d +: 8];
            add_b_d   = b_d[8*idx_d +: 8];
            add_cin_d = carry_d;
        end

        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            add_a_q     <= 8'd0;
            add_b_q     <= 8'd0;
            add_cin_q   <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_cin_q   <= add_cin_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = carry_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_add8_seq.sv
// Scoreboard bench for add8_seq: WORDS=4 instance under random and directed traffic,
// plus a small directed run on a WORDS=1 instance.
module tb_add8_seq;

    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = 8 * WORDS;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         req_valid, req_ready;
    logic [W-1:0] op_a, op_b;
    logic         op_cin;
    logic         rsp_valid, rsp_ready;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout;
    logic [7:0]   add_a, add_b, add_sum;
    logic         add_cin, add_cout;
    logic         busy;

    logic         req_valid1, req_ready1;
    logic [7:0]   op_a1, op_b1;
    logic         op_cin1;
    logic         rsp_valid1, rsp_ready1;
    logic [7:0]   rsp_sum1;
    logic         rsp_cout1;
    logic [7:0]   add_a1, add_b1, add_sum1;
    logic         add_cin1, add_cout1;
    logic         busy1;

    add8_seq #(.WORDS(WORDS)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .busy(busy)
    );

    add8_seq #(.WORDS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid1), .req_ready(req_ready1),
        .op_a(op_a1), .op_b(op_b1), .op_cin(op_cin1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_sum(rsp_sum1), .rsp_cout(rsp_cout1),
        .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
        .add_sum(add_sum1), .add_cout(add_cout1),
        .busy(busy1)
    );

    // The shared external add8
    assign {add_cout, add_sum}   = 9'(add_a) + 9'(add_b) + 9'(add_cin);
    assign {add_cout1, add_sum1} = 9'(add_a1) + 9'(add_b1) + 9'(add_cin1);

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int bp_mode  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // rsp_ready policy: 0 = always ready, 1 = random, 2 = stalled
    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'($urandom_range(0, 1));
            default: rsp_ready = 1'b0;
        endcase
    end

    // Scoreboard / reference model state
    logic [W:0]   exp_q[$];
    logic [W-1:0] cur_a, cur_b;
    logic         cur_cin;
    int           acc_cyc = 0;
    bit           pending = 1'b0;
    int           mon_j;
    logic [W:0]   mon_m, mon_t;
    logic [7:0]   e_a, e_b;
    logic         e_cin;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_req_ready", 64'(req_ready), 64'd1);
            check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            check("rst_rsp_sum",   64'(rsp_sum),   64'd0);
            check("rst_rsp_cout",  64'(rsp_cout),  64'd0);
            check("rst_add_drive", {47'd0, add_a, add_b, add_cin}, 64'd0);
            check("rst_busy",      64'(busy),      64'd0);
            exp_q.delete();
            pending = 1'b0;
        end else begin
            check("req_ready", 64'(req_ready), 64'(!pending));
            check("busy",      64'(busy),      64'(pending));
            mon_j = cyc - acc_cyc;
            e_a = 8'd0; e_b = 8'd0; e_cin = 1'b0;
            if (pending && mon_j >= 0 && mon_j < int'(WORDS)) begin
                // Byte j of each operand; carry into byte j from the arithmetic sum of the lower bytes
                e_a   = 8'(cur_a >> (8 * mon_j));
                e_b   = 8'(cur_b >> (8 * mon_j));
                mon_m = ((W+1)'(1) << (8 * mon_j)) - (W+1)'(1);
                mon_t = ((W+1)'(cur_a) & mon_m) + ((W+1)'(cur_b) & mon_m) + (W+1)'(cur_cin);
                e_cin = mon_t[8 * mon_j];
            end
            check("add_a",   64'(add_a),   64'(e_a));
            check("add_b",   64'(add_b),   64'(e_b));
            check("add_cin", 64'(add_cin), 64'(e_cin));
            check("rsp_valid", 64'(rsp_valid), 64'(pending && mon_j >= int'(WORDS)));
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected actual=valid required=no response");
                end else begin
                    check("rsp_sum",  64'(rsp_sum),  64'(exp_q[0][W-1:0]));
                    check("rsp_cout", 64'(rsp_cout), 64'(exp_q[0][W]));
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        pending = 1'b0;
                    end
                end
            end
            if (req_valid && req_ready) begin
                exp_q.push_back((W+1)'(op_a) + (W+1)'(op_b) + (W+1)'(op_cin));
                cur_a   = op_a;
                cur_b   = op_b;
                cur_cin = op_cin;
                acc_cyc = cyc + 1;
                pending = 1'b1;
            end
        end
    end

    task automatic do_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input int hold);
        int n = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; op_a = a; op_b = b; op_cin = cin;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 100) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout actual=req_ready low required=accept within 100 cycles");
                req_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        op_a = W'($urandom); op_b = W'($urandom); op_cin = 1'($urandom);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (pending || exp_q.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL idle_timeout actual=busy required=response within 200 cycles");
                return;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; op_a = '0; op_b = '0; op_cin = 1'b0;
        req_valid1 = 1'b0; op_a1 = 8'd0; op_b1 = 8'd0; op_cin1 = 1'b0; rsp_ready1 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Carry across bytes, then a full ripple
        do_req(32'h0000_00FF, 32'h0000_0001, 1'b0, 0);
        wait_idle();
        do_req(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0);
        wait_idle();

        // Backpressure with req_valid held through RUN and DONE
        bp_mode = 2;
        do_req(32'h1234_5678, 32'h1111_1111, 1'b0, WORDS + 5);
        bp_mode = 0;
        wait_idle();

        // Reset after two RUN cycles
        do_req(W'($urandom), W'($urandom), 1'b0, 0);
        @(posedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        do_req(32'h0000_0001, 32'h0000_0001, 1'b0, 0);
        wait_idle();

        // Random traffic with random backpressure and operand churn after accept
        bp_mode = 1;
        for (int i = 0; i < 40; i++) begin
            do_req(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 2));
        end
        bp_mode = 0;
        wait_idle();

        // WORDS=1 instance: one-cycle RUN
        @(posedge clk); #1;
        req_valid1 = 1'b1; op_a1 = 8'hFF; op_b1 = 8'h01; op_cin1 = 1'b0;
        @(negedge clk);
        check("w1_req_ready", 64'(req_ready1), 64'd1);
        @(posedge clk); #1 req_valid1 = 1'b0;
        @(negedge clk);
        check("w1_add_drive", {47'd0, add_a1, add_b1, add_cin1}, {47'd0, 8'hFF, 8'h01, 1'b0});
        check("w1_busy",      64'(busy1),      64'd1);
        check("w1_rsp_early", 64'(rsp_valid1), 64'd0);
        @(negedge clk);
        check("w1_rsp_valid", 64'(rsp_valid1), 64'd1);
        check("w1_rsp_sum",   64'(rsp_sum1),   64'h00);
        check("w1_rsp_cout",  64'(rsp_cout1),  64'd1);
        @(negedge clk);
        check("w1_idle_valid", 64'(rsp_valid1), 64'd0);
        check("w1_idle_ready", 64'(req_ready1), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
